// File: rtl/window_coord_gen.sv
// Window coordinate generator: walks a (2*RADIUS+1)^2 neighbourhood around a latched
// centre in row-major order, with edge clamp/flag, valid/ready flow control and chaining.
module window_coord_gen #(
   parameter int COORD_W   = 8,
   parameter int RADIUS    = 1,
   parameter int IMG_W     = 256,
   parameter int IMG_H     = 256,
   parameter int EDGE_MODE = 0,
   parameter int IDX_W     = $clog2((2*RADIUS+1)*(2*RADIUS+1))
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] xCenter,
   input  logic [COORD_W-1:0] yCenter,
   input  logic               startGet,
   output logic               startReady,
   output logic               busy,
   output logic [COORD_W-1:0] xWindow,
   output logic [COORD_W-1:0] yWindow,
   output logic               windowOut,
   input  logic               windowReady,
   output logic               oob,
   output logic               first,
   output logic               last,
   output logic [IDX_W-1:0]   sampleIdx
);

   localparam int SW = COORD_W + 2;
   localparam int NS = (2*RADIUS+1) * (2*RADIUS+1);
   localparam logic signed [SW-1:0]  R_POS    = SW'(RADIUS);
   localparam logic signed [SW-1:0]  R_NEG    = SW'(-RADIUS);
   localparam logic signed [SW-1:0]  X_MAX    = SW'(IMG_W - 1);
   localparam logic signed [SW-1:0]  Y_MAX    = SW'(IMG_H - 1);
   localparam logic [COORD_W-1:0]    X_LAST   = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0]    Y_LAST   = COORD_W'(IMG_H - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NS - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                state_q, state_d;
   logic [COORD_W-1:0]    xc_q, xc_d, yc_q, yc_d;
   logic signed [SW-1:0]  xoff_q, xoff_d, yoff_q, yoff_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [COORD_W-1:0]    xw_q, xw_d, yw_q, yw_d;
   logic                  oob_q, oob_d, first_q, first_d, last_q, last_d;
   logic                  hs, start_ok;
   logic signed [SW-1:0]  xraw, yraw;
   logic                  x_lo, x_hi, y_lo, y_hi;

   always_comb begin
      hs         = (state_q == S_RUN) && windowReady;
      startReady = (state_q == S_IDLE) || (hs && last_q);
      start_ok   = startGet && startReady;

      state_d = state_q;
      xc_d    = xc_q;
      yc_d    = yc_q;
      xoff_d  = xoff_q;
      yoff_d  = yoff_q;
      idx_d   = idx_q;

      if (start_ok) begin
         state_d = S_RUN;
         xc_d    = (xCenter > X_LAST) ? X_LAST : xCenter;
         yc_d    = (yCenter > Y_LAST) ? Y_LAST : yCenter;
         xoff_d  = R_NEG;
         yoff_d  = R_NEG;
         idx_d   = '0;
      end else if (hs) begin
         if (last_q) begin
            state_d = S_IDLE;
            xoff_d  = R_NEG;
            yoff_d  = R_NEG;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
            if (xoff_q == R_POS) begin
               xoff_d = R_NEG;
               yoff_d = yoff_q + SW'(1);
            end else begin
               xoff_d = xoff_q + SW'(1);
            end
         end
      end

      // Outputs are computed from the next position so they appear one edge after it is chosen.
      xraw = $signed({2'b00, xc_d}) + xoff_d;
      yraw = $signed({2'b00, yc_d}) + yoff_d;
      x_lo = xraw < 0;
      x_hi = xraw > X_MAX;
      y_lo = yraw < 0;
      y_hi = yraw > Y_MAX;

      xw_d    = x_lo ? '0 : (x_hi ? X_LAST : xraw[COORD_W-1:0]);
      yw_d    = y_lo ? '0 : (y_hi ? Y_LAST : yraw[COORD_W-1:0]);
      oob_d   = (EDGE_MODE == 1) ? (x_lo || x_hi || y_lo || y_hi) : 1'b0;
      first_d = (idx_d == '0);
      last_d  = (idx_d == IDX_LAST);

      if (state_d == S_IDLE) begin
         xw_d    = '0;
         yw_d    = '0;
         oob_d   = 1'b0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         xc_q    <= '0;
         yc_q    <= '0;
         xoff_q  <= R_NEG;
         yoff_q  <= R_NEG;
         idx_q   <= '0;
         xw_q    <= '0;
         yw_q    <= '0;
         oob_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xc_q    <= xc_d;
         yc_q    <= yc_d;
         xoff_q  <= xoff_d;
         yoff_q  <= yoff_d;
         idx_q   <= idx_d;
         xw_q    <= xw_d;
         yw_q    <= yw_d;
         oob_q   <= oob_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign windowOut = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN);
   assign xWindow   = xw_q;
   assign yWindow   = yw_q;
   assign oob       = oob_q;
   assign first     = first_q;
   assign last      = last_q;
   assign sampleIdx = idx_q;

endmodule

// File: tb/tb_window_coord_gen.sv
// Bench for window_coord_gen: three configurations driven with shared stimulus and
// checked every cycle against a queue-of-expected-samples model, plus literal expectations.
module tb_window_coord_gen;

   logic       clk = 1'b0;
   logic       reset, startGet, windowReady;
   logic [7:0] xCenter, yCenter;

   logic       sr[3], bz[3], wo[3], oo[3], fi[3], la[3];
   logic [7:0] xw[3], yw[3], ix[3];
   logic [3:0] idx0, idx1;
   logic [4:0] idx2;

   always #5 clk = ~clk;

   assign ix[0] = {4'b0, idx0};
   assign ix[1] = {4'b0, idx1};
   assign ix[2] = {3'b0, idx2};

   window_coord_gen #(.COORD_W(8), .RADIUS(1), .IMG_W(256), .IMG_H(256), .EDGE_MODE(0)) u_clamp (
      .clk(clk), .reset(reset), .xCenter(xCenter), .yCenter(yCenter), .startGet(startGet),
      .startReady(sr[0]), .busy(bz[0]), .xWindow(xw[0]), .yWindow(yw[0]), .windowOut(wo[0]),
      .windowReady(windowReady), .oob(oo[0]), .first(fi[0]), .last(la[0]), .sampleIdx(idx0));

   window_coord_gen #(.COORD_W(8), .RADIUS(1), .IMG_W(256), .IMG_H(256), .EDGE_MODE(1)) u_flag (
      .clk(clk), .reset(reset), .xCenter(xCenter), .yCenter(yCenter), .startGet(startGet),
      .startReady(sr[1]), .busy(bz[1]), .xWindow(xw[1]), .yWindow(yw[1]), .windowOut(wo[1]),
      .windowReady(windowReady), .oob(oo[1]), .first(fi[1]), .last(la[1]), .sampleIdx(idx1));

   window_coord_gen #(.COORD_W(8), .RADIUS(2), .IMG_W(64), .IMG_H(64), .EDGE_MODE(0)) u_r2 (
      .clk(clk), .reset(reset), .xCenter(xCenter), .yCenter(yCenter), .startGet(startGet),
      .startReady(sr[2]), .busy(bz[2]), .xWindow(xw[2]), .yWindow(yw[2]), .windowOut(wo[2]),
      .windowReady(windowReady), .oob(oo[2]), .first(fi[2]), .last(la[2]), .sampleIdx(idx2));

   typedef struct {
      int x; int y; int oob; int first; int last; int idx; int cyc;
   } smp_t;

   smp_t q[3][$];
   smp_t lg[3][$];
   int   rr[3] = '{1, 1, 2};
   int   wd[3] = '{256, 256, 64};
   int   em[3] = '{0, 1, 0};
   int   n_chk = 0, n_fail = 0, cyc = 0;
   bit   armed = 1'b0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // All three images are square, so wd serves for both axes.
   function automatic smp_t mk(int d, int cx, int cy, int i);
      smp_t s;
      int k, ccx, ccy, rx, ry;
      k   = 2*rr[d] + 1;
      ccx = (cx > wd[d]-1) ? wd[d]-1 : cx;
      ccy = (cy > wd[d]-1) ? wd[d]-1 : cy;
      rx  = ccx + i % k - rr[d];
      ry  = ccy + i / k - rr[d];
      s.x = (rx < 0) ? 0 : ((rx > wd[d]-1) ? wd[d]-1 : rx);
      s.y = (ry < 0) ? 0 : ((ry > wd[d]-1) ? wd[d]-1 : ry);
      s.oob   = (em[d] == 1 && (rx != s.x || ry != s.y)) ? 1 : 0;
      s.first = (i == 0) ? 1 : 0;
      s.last  = (i == k*k-1) ? 1 : 0;
      s.idx   = i;
      s.cyc   = 0;
      return s;
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         for (int d = 0; d < 3; d++) begin
            smp_t e, a;
            int   busy_m, rdy_m, k;
            k      = 2*rr[d] + 1;
            busy_m = (q[d].size() > 0) ? 1 : 0;
            rdy_m  = (q[d].size() == 0 || (q[d].size() == 1 && windowReady)) ? 1 : 0;
            chk($sformatf("d%0d_windowOut", d), int'(wo[d]), busy_m);
            chk($sformatf("d%0d_busy", d), int'(bz[d]), busy_m);
            chk($sformatf("d%0d_startReady", d), int'(sr[d]), rdy_m);
            if (busy_m == 1) begin
               e = q[d][0];
               chk($sformatf("d%0d_x", d), int'(xw[d]), e.x);
               chk($sformatf("d%0d_y", d), int'(yw[d]), e.y);
               chk($sformatf("d%0d_oob", d), int'(oo[d]), e.oob);
               chk($sformatf("d%0d_first", d), int'(fi[d]), e.first);
               chk($sformatf("d%0d_last", d), int'(la[d]), e.last);
               chk($sformatf("d%0d_idx", d), int'(ix[d]), e.idx);
            end
            if (reset) begin
               q[d].delete();
            end else begin
               if (busy_m == 1 && windowReady) begin
                  a.x = int'(xw[d]); a.y = int'(yw[d]); a.oob = int'(oo[d]);
                  a.first = int'(fi[d]); a.last = int'(la[d]); a.idx = int'(ix[d]); a.cyc = cyc;
                  lg[d].push_back(a);
                  void'(q[d].pop_front());
               end
               if (startGet && rdy_m == 1)
                  for (int i = 0; i < k*k; i++) q[d].push_back(mk(d, int'(xCenter), int'(yCenter), i));
            end
         end
      end
      cyc++;
   end

   task automatic clear_logs();
      for (int d = 0; d < 3; d++) lg[d].delete();
   endtask

   task automatic start(int cx, int cy);
      startGet = 1'b1;
      xCenter  = 8'(cx);
      yCenter  = 8'(cy);
      @(posedge clk); #1;
      startGet = 1'b0;
   endtask

   task automatic wait_idle(int lim);
      int n;
      n = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", q[0].size() + q[1].size() + q[2].size(), 0);
      @(posedge clk); #1;
   endtask

   int ex_x1[9]  = '{29, 30, 31, 29, 30, 31, 29, 30, 31};
   int ex_y1[9]  = '{29, 29, 29, 30, 30, 30, 31, 31, 31};
   int ex_xb[9]  = '{32, 33, 34, 32, 33, 34, 32, 33, 34};
   int ex_xc[9]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
   int ex_yc[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
   int ex_oob[9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};

   initial begin
      reset = 1'b1; startGet = 1'b0; windowReady = 1'b1; xCenter = '0; yCenter = '0;
      @(posedge clk); #1;
      armed = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_windowOut", int'(wo[0]), 0);
      chk("rst_x", int'(xw[0]), 0);
      chk("rst_idx", int'(ix[0]), 0);
      chk("rst_startReady", int'(sr[0]), 1);

      // Basic window, full-rate drain
      clear_logs();
      start(30, 30);
      wait_idle(60);
      chk("basic_count", lg[0].size(), 9);
      if (lg[0].size() == 9) begin
         for (int i = 0; i < 9; i++) begin
            chk($sformatf("basic_x%0d", i), lg[0][i].x, ex_x1[i]);
            chk($sformatf("basic_y%0d", i), lg[0][i].y, ex_y1[i]);
            chk($sformatf("basic_first%0d", i), lg[0][i].first, (i == 0) ? 1 : 0);
            chk($sformatf("basic_last%0d", i), lg[0][i].last, (i == 8) ? 1 : 0);
         end
         chk("basic_span", lg[0][8].cyc - lg[0][0].cyc, 8);
      end
      chk("basic_idle_wo", int'(wo[0]), 0);
      chk("basic_idle_busy", int'(bz[0]), 0);

      // Back-pressure: ready high one cycle in three
      clear_logs();
      startGet = 1'b1; xCenter = 8'd33; yCenter = 8'd33;
      for (int i = 0; i < 90; i++) begin
         windowReady = (i % 3 == 0);
         @(posedge clk); #1;
         startGet = 1'b0;
      end
      windowReady = 1'b1;
      wait_idle(60);
      chk("bp_count", lg[0].size(), 9);
      if (lg[0].size() == 9) begin
         for (int i = 0; i < 9; i++) chk($sformatf("bp_x%0d", i), lg[0][i].x, ex_xb[i]);
         chk("bp_span", lg[0][8].cyc - lg[0][0].cyc, 24);
         chk("bp_y8", lg[0][8].y, 34);
      end

      // Corner, clamp versus flag
      clear_logs();
      start(0, 0);
      wait_idle(60);
      chk("corner_count0", lg[0].size(), 9);
      chk("corner_count1", lg[1].size(), 9);
      if (lg[0].size() == 9 && lg[1].size() == 9) begin
         for (int i = 0; i < 9; i++) begin
            chk($sformatf("corner_x%0d", i), lg[0][i].x, ex_xc[i]);
            chk($sformatf("corner_y%0d", i), lg[0][i].y, ex_yc[i]);
            chk($sformatf("corner_oob_clamp%0d", i), lg[0][i].oob, 0);
            chk($sformatf("corner_fx%0d", i), lg[1][i].x, ex_xc[i]);
            chk($sformatf("corner_oob_flag%0d", i), lg[1][i].oob, ex_oob[i]);
         end
      end

      // Chaining on the final handshake
      clear_logs();
      start(30, 30);
      for (int i = 0; i < 20; i++) begin
         if (la[0]) break;
         @(posedge clk); #1;
      end
      chk("chain_reach_last", int'(la[0]), 1);
      startGet = 1'b1; xCenter = 8'd33; yCenter = 8'd33;
      @(posedge clk); #1;
      startGet = 1'b0;
      chk("chain_wo", int'(wo[0]), 1);
      chk("chain_x", int'(xw[0]), 32);
      chk("chain_y", int'(yw[0]), 32);
      chk("chain_first", int'(fi[0]), 1);
      wait_idle(60);
      chk("chain_count", lg[0].size(), 18);
      if (lg[0].size() == 18) begin
         chk("chain_span", lg[0][17].cyc - lg[0][0].cyc, 17);
         chk("chain_s9x", lg[0][9].x, 32);
         chk("chain_s8last", lg[0][8].last, 1);
         chk("chain_s17y", lg[0][17].y, 34);
      end

      // Reset mid-window
      start(30, 30);
      for (int i = 0; i < 20; i++) begin
         if (ix[0] == 8'd4) break;
         @(posedge clk); #1;
      end
      chk("mid_reach_idx4", int'(ix[0]), 4);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_wo", int'(wo[0]), 0);
      chk("mid_busy", int'(bz[0]), 0);
      chk("mid_x", int'(xw[0]), 0);
      chk("mid_y", int'(yw[0]), 0);
      chk("mid_idx", int'(ix[0]), 0);
      chk("mid_last", int'(la[0]), 0);
      chk("mid_ready", int'(sr[0]), 1);
      start(10, 10);
      chk("mid_restart_x", int'(xw[0]), 9);
      chk("mid_restart_y", int'(yw[0]), 9);
      chk("mid_restart_idx", int'(ix[0]), 0);
      chk("mid_restart_first", int'(fi[0]), 1);
      wait_idle(60);

      // RADIUS=2 near the right edge of a 64x64 image
      clear_logs();
      start(63, 5);
      wait_idle(80);
      chk("r2_count", lg[2].size(), 25);
      if (lg[2].size() == 25) begin
         chk("r2_s0x", lg[2][0].x, 61);
         chk("r2_s0y", lg[2][0].y, 3);
         chk("r2_s3x", lg[2][3].x, 63);
         chk("r2_s4x", lg[2][4].x, 63);
         chk("r2_s24x", lg[2][24].x, 63);
         chk("r2_s24y", lg[2][24].y, 7);
         chk("r2_s24idx", lg[2][24].idx, 24);
         chk("r2_s24last", lg[2][24].last, 1);
         chk("r2_s23last", lg[2][23].last, 0);
      end

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         reset       = ($urandom_range(0, 99) == 0);
         startGet    = ($urandom_range(0, 2) == 0);
         windowReady = ($urandom_range(0, 3) != 0);
         xCenter     = 8'($urandom_range(0, 255));
         yCenter     = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
      reset = 1'b0; startGet = 1'b0; windowReady = 1'b1;
      wait_idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/window_coord_gen.md
Name: window_coord_gen

Overview:
Parametrised successor to the fixed 3x3 window coordinate generator. Latches a centre pixel coordinate and emits every coordinate of a (2*RADIUS+1)^2 neighbourhood, one per accepted beat, in row-major order. Adds image-edge handling (clamp or flag), valid/ready back-pressure, first/last/index sideband and back-to-back window chaining. Sits between the pixel scheduler and the frame-buffer read port feeding the median sorter.

Parameters:
COORD_W, 8, width of x/y coordinates (unsigned)
RADIUS, 1, window half-size; window side K = 2*RADIUS+1, K*K samples per window (RADIUS >= 1)
IMG_W, 256, image width in pixels; valid x is 0..IMG_W-1 (IMG_W <= 2^COORD_W)
IMG_H, 256, image height in pixels; valid y is 0..IMG_H-1
EDGE_MODE, 0, 0 = clamp (replicate border), 1 = flag (coordinate clamped, oob asserted)
IDX_W, clog2(K*K), width of sample index

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
xCenter  in  COORD_W  window centre x, sampled on start acceptance
yCenter  in  COORD_W  window centre y, sampled on start acceptance
startGet  in  1  request a new window; accepted when startReady=1
startReady  out  1  1 in IDLE, or on the final beat's handshake cycle (chaining)
busy  out  1  1 while in RUN
xWindow  out  COORD_W  current sample x
yWindow  out  COORD_W  current sample y
windowOut  out  1  sample valid
windowReady  in  1  downstream accepts sample when windowOut & windowReady
oob  out  1  sample's raw coordinate lay outside the image (EDGE_MODE=1 only; else 0)
first  out  1  sample is offset (-R,-R)
last  out  1  sample is offset (+R,+R)
sampleIdx  out  IDX_W  0..K*K-1, row-major position in window

Behaviour:
- Reset (sync, any state, including mid-window): state IDLE, windowOut=0, busy=0, xWindow=yWindow=0, oob=first=last=0, sampleIdx=0, offsets=-R. In-flight window discarded, no last emitted.
- All outputs registered. Two states: IDLE, RUN.
- IDLE: startReady=1. startGet=1 at edge n: latch centre, set xOff=yOff=-R, go RUN. The first sample is valid after edge n, i.e. in cycle n+1 (latency 1).
- Centre clipping at latch: xCenter > IMG_W-1 is treated as IMG_W-1; likewise y.
- RUN: windowOut=1. Outputs hold stable while windowReady=0.
- On each handshake, advance: xOff++ until +R, then xOff=-R and yOff++. sampleIdx++. first is true only at idx 0; last is true only at idx K*K-1.
- Coordinate arithmetic: signed, COORD_W+2 bits, raw = centre + offset. Clamp to [0, IMG_W-1] / [0, IMG_H-1]. oob = (raw != clamped) && EDGE_MODE==1.
- Final-beat handshake:
  - If startGet=1 in the same cycle (startReady=1): latch the new centre, restart at idx 0, stay RUN. No bubble; windowOut stays 1.
  - Else go IDLE: windowOut=0 next cycle.
- startGet in RUN other than on the final handshake is ignored. startReady=0 in that case.
- Offsets and the sample counter are sized so RADIUS up to 7 does not wrap.

Test Plan:
- RADIUS=1, centre (30,30), windowReady=1, startGet pulse at cycle 0:
  - Cycles 1..9 emit (29,29),(30,29),(31,29),(29,30)...(31,31).
  - first only at cycle 1; last only at cycle 9, idx 8.
  - windowOut=0 from cycle 10; busy follows.
- Back-pressure, centre (33,33), windowReady toggling 1,0,0,1...:
  - Outputs hold through stalled cycles.
  - Exactly 9 handshakes, same sequence, no sample dropped or repeated.
- Corner (0,0):
  - EDGE_MODE=0 emits (0,0),(0,0),(1,0),(0,0),(0,0),(1,0),(0,1),(0,1),(1,1) with oob=0.
  - EDGE_MODE=1 emits the same coordinates with oob=1,1,1,1,0,0,1,0,0.
- Chaining: startGet=1 with centre (33,33) on last handshake of window (30,30):
  - Next cycle shows (32,32), first=1.
  - windowOut never drops; 18 contiguous samples.
- Reset asserted at idx 4 of a window:
  - Next cycle all outputs 0, IDLE.
  - Subsequent start at (10,10) begins cleanly at (9,9), idx 0.
- RADIUS=2, IMG_W=IMG_H=64, centre (63,5):
  - 25 samples, x saturates at 63.
  - sampleIdx reaches 24 with last=1.
